// File: rtl/data_mem_responder.sv
// M-stage data-memory responder: word-addressed local SRAM with programmable wait states,
// byte/halfword lane handling, load sign/zero extension and alignment checking.
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err
);

  localparam int unsigned AW = ADDR_W + 2;  // byte-address bits that reach the array

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          we_q, we_d;
  logic          sgn_q, sgn_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [2**ADDR_W];

  logic          req_err;
  logic          do_access;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    acc_size;
  logic          acc_we;
  logic          acc_sgn;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [31:0]   ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // Upper address bits alias onto the array.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW];

  assign req_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = req_addr[AW-1:0];
      acc_wdata = req_wdata;
      acc_size  = req_size;
      acc_we    = req_we;
      acc_sgn   = req_signed;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_we    = we_q;
      acc_sgn   = sgn_q;
    end
  end

  assign do_access = ((state_q == StIdle) && req_valid && !req_err && (LATENCY == 0)) ||
                     ((state_q == StWait) && (cnt_q == 4'd1));

  assign rd_word = mem_q[acc_addr[AW-1:2]];

  always_comb begin
    wr_word = rd_word;
    ld_data = rd_word;
    ld_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    ld_half = rd_word[{acc_addr[1], 4'b0000} +: 16];
    case (acc_size)
      2'b00: begin
        wr_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
        ld_data = {{24{acc_sgn & ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        wr_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
        ld_data = {{16{acc_sgn & ld_half[15]}}, ld_half};
      end
      default: wr_word = acc_wdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          size_d  = req_size;
          we_d    = req_we;
          sgn_d   = req_signed;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = StResp;
          end else if (LATENCY == 0) begin
            rdata_d = req_we ? 32'd0 : ld_data;
            state_d = StResp;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = we_q ? 32'd0 : ld_data;
          state_d = StResp;
        end
      end
      StResp: begin
        // Response data and error are single-cycle; clear them on the way out.
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is never cleared; a reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_we) begin
      mem_q[acc_addr[AW-1:2]] <= wr_word;
    end
  end

  assign stall      = ((state_q == StIdle) && req_valid) || (state_q == StWait);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign addr_err   = err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the pipeline's M-stage data accesses. It receives load/store requests driven from aluoutM/writedataM/readdataM-stage control, and holds them in a local word-addressed SRAM array with configurable wait states. It drives a stall back to the hazard unit until the access completes. It also performs byte/halfword lane selection, load sign/zero extension and alignment checking.

Parameters:
ADDR_W, 10, word-address width; the array holds 2^ADDR_W 32-bit words.
LATENCY, 2, wait-state cycles between request acceptance and access; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  M-stage memory access present; held stable by CPU while stall=1
req_we  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=halfword, 10=word, 11=reserved
req_signed  input  1  load extension: 1=sign-extend, 0=zero-extend
req_addr  input  32  byte address (aluoutM)
req_wdata  input  32  store data, right-justified (writedataM)
stall  output  1  combinational; high while request not yet completed
resp_valid  output  1  one-cycle pulse: access completed
resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores and errors
addr_err  output  1  one-cycle pulse with resp_valid on misaligned/reserved request

Behaviour:
- States: IDLE, WAIT, RESP. Registered: state, cnt[3:0], latched addr/wdata/size/we/signed, resp_rdata, addr_err.
- Reset: state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, addr_err=0, stall=0. Array contents are not cleared. Reset wins over every other event at the same edge.
- stall = (state==IDLE & req_valid) | (state==WAIT). stall=0 in RESP.
- IDLE, req_valid=0: stay in IDLE.
- IDLE, req_valid=1, error: error means req_size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=00. Latch error and go to RESP. No array access. resp_rdata=0.
- IDLE, req_valid=1, legal: latch all request fields.
  - LATENCY=0: perform access at this edge and go to RESP.
  - Otherwise: cnt=LATENCY, go to WAIT.
- WAIT: cnt decrements each cycle. At the edge where cnt==1, perform access and go to RESP.
- RESP: resp_valid=1, addr_err as latched. Next state is IDLE unconditionally. The request present during RESP is the consumed one and is never re-accepted.
- Timing: request first seen in cycle 0. stall is high for cycles 0..LATENCY. resp_valid is high in cycle LATENCY+1. Back-to-back requests: the next request is accepted in the cycle after RESP.
- Array index: addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias/wrap modulo 2^(ADDR_W+2).
- Store lanes:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: addr[1]=0 writes bits[15:0], addr[1]=1 writes bits[31:16], from wdata[15:0].
  - word: all 32 bits.
  - Unselected bytes are preserved (read-modify-write on the same edge is allowed).
  - resp_rdata=0 for stores.
- Load: select the same lane, then sign- or zero-extend per latched signed. The word result ignores signed.
- Load data reflects all stores completed at earlier edges.
- req_valid deasserting during WAIT is a protocol violation. The latched request still completes normally.
- Reset during WAIT: return to IDLE. No write occurs, because the write edge never happens. No resp_valid.

Test Plan:
- Word store then load, LATENCY=2: store addr 0x10 data 0xDEADBEEF, then load word 0x10 -> stall high 3 cycles each, resp_valid in cycle 3, resp_rdata=0xDEADBEEF, addr_err=0.
- Byte/half lanes: store word 0x00000000 at 0x20, store byte 0x80 at 0x23, store half 0x1234 at 0x20 -> load word=0x80001234. Load byte signed 0x23=0xFFFFFF80, unsigned=0x00000080. Load half signed 0x22=0xFFFF8000.
- Misalignment: load word at 0x22, half at 0x21, size=11 at 0x40 -> each gives stall for exactly 1 cycle, then resp_valid+addr_err pulse, resp_rdata=0, memory word at 0x20 unchanged.
- LATENCY=0 back-to-back: two consecutive loads -> stall 1 cycle each, resp_valid pulses in cycles 1 and 3, no request dropped or duplicated.
- Reset mid-WAIT: store 0xCAFEF00D to 0x30 with LATENCY=4, assert rst in cycle 2 -> stall drops after the reset edge, no resp_valid, a later load of 0x30 returns the prior contents.
- Aliasing (ADDR_W=10): store 0x11111111 at 0x1004 -> load 0x0004 returns 0x11111111.
